// File: rtl/uart_pkg.sv
// Shared state encoding and frame constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the rotating pointer with wrap and
// advances the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       idx,
  output logic             valid
);

  logic [2:0] ptr;
  int         cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!valid && (j == cand) && req[j]) begin
          grant[j] = 1'b1;
          idx      = 3'(j);
          valid    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 3'd0;
    end else if (en && valid) begin
      ptr <= (idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit line between N_REQ byte requesters (8N1 frames).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] PDin,
  output logic [N_REQ-1:0]   Ack,
  output logic [2:0]         Gnt_id,
  output logic               Busy,
  output logic               SCout,
  output logic               SDout
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t      state, state_next;
  logic [CW-1:0]    baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       sel_byte;
  logic [N_REQ-1:0] grant;
  logic [2:0]       arb_idx;
  logic             arb_valid;
  logic             latch;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_bit;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (Clk),
    .rst_n (Rst_n),
    .req   (Req),
    .en    (latch),
    .grant (grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Requests are only looked at while idle, so mid-frame Req changes are moot.
  assign latch   = (state == ST_IDLE) && arb_valid;
  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign Busy    = (state != ST_IDLE);
  assign SCout   = Busy && (baud_cnt == '0);

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_byte = sel_byte | PDin[8*i +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (arb_valid) state_next = ST_START;
      ST_START: if (bit_end) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_cnt == 3'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (bit_end) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Baud/bit counters and shifter restart on every latch so each frame is clean.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      Ack      <= '0;
      Gnt_id   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      Ack <= '0;
      if (latch) begin
        shreg    <= sel_byte;
        Gnt_id   <= arb_idx;
        Ack      <= grant;
        baud_cnt <= '0;
        bit_cnt  <= 3'd0;
`ifdef UART_TX_PARITY_EN
        par_bit  <= ^sel_byte;
`endif
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == ST_DATA) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    SDout = STOP_BIT;
    case (state)
      ST_START: SDout = START_BIT;
      ST_DATA:  SDout = shreg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: SDout = par_bit;
`endif
      default:  SDout = STOP_BIT;
    endcase
  end

endmodule
